// File: rtl/cpu_trace_pkg.sv
// Shared definitions for the CPU trace LCD formatter: FSM states, frame
// length, ASCII constants and the nibble-to-hex-character helper.
package cpu_trace_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CLR       = 3'd1,
    ST_CLR_WAIT  = 3'd2,
    ST_CHAR      = 3'd3,
    ST_CHAR_WAIT = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

  localparam int FRAME_LEN = 16;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_BANG  = 8'h21;
  localparam logic [7:0] ASCII_O     = 8'h4F;
  localparam logic [7:0] ASCII_A     = 8'h41;
  localparam logic [7:0] ASCII_X     = 8'h58;
  localparam logic [7:0] ASCII_Y     = 8'h59;

  // Uppercase hex digit: 0-9 -> '0'-'9', A-F -> 'A'-'F'.
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end
    return 8'h37 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Small synchronous FIFO of register snapshots. A push into a full FIFO is
// dropped and flagged on 'drop' unless a pop frees a slot in the same cycle.
module trace_fifo #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic             drop
);

  localparam logic [PTR_W-1:0] PTR_ONE  = 1;
  localparam logic [PTR_W:0]   CNT_ONE  = 1;
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CNT_FULL);
  assign empty   = (count_reg == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle makes room, so the push is still accepted.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;
  assign rd_data = mem[rd_ptr_reg];

  // Storage array; no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/cpu_trace_lcd_fmt.sv
// CPU register trace formatter: captures {opcode, accum, xreg, yreg} on each
// rising edge of the slow phase strobe, queues snapshots and streams each one
// to lcd_control as a 16-character ASCII line "Ohh Ahh Xhh Yhh ".
// Optional macro TRACE_OVF_MARK_EN: the last character becomes '!' while the
// sticky overflow flag is set.
module cpu_trace_lcd_fmt
  import cpu_trace_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_W      = $clog2(FIFO_DEPTH)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       snap_strobe,
  input  logic [7:0] accum,
  input  logic [7:0] xreg,
  input  logic [7:0] yreg,
  input  logic [7:0] opcode,
  input  logic       initDone,
  input  logic       writeDone,
  output logic       writeStart,
  output logic       clrLCD,
  output logic [7:0] data,
  output logic       overflow,
  output logic       busy
);

  logic        sync1_reg, sync2_reg, prev_reg;
  logic        strobe_edge;
  logic [31:0] snap_word;
  logic [31:0] fifo_rd_data;
  logic        fifo_full, fifo_empty, fifo_drop, fifo_pop;

  state_t      state_reg, state_next;
  logic [4:0]  idx_reg, idx_next;
  logic [31:0] frame_reg;
  logic [7:0]  data_reg;
  logic        overflow_reg;
  logic [7:0]  frame_chars [FRAME_LEN];
  logic [7:0]  cur_char;

  // Two-flop synchronizer plus a delayed copy for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      prev_reg  <= 1'b0;
    end else begin
      sync1_reg <= snap_strobe;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  assign strobe_edge = sync2_reg & ~prev_reg;
  // Taps are sampled directly on the edge cycle; they are stable long before
  // the slow strobe has crossed the synchronizer.
  assign snap_word   = {opcode, accum, xreg, yreg};

  trace_fifo #(
    .DEPTH (FIFO_DEPTH),
    .PTR_W (PTR_W),
    .WIDTH (32)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (strobe_edge),
    .wr_data (snap_word),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .drop    (fifo_drop)
  );

  // Character table for the current frame: four groups of letter, high
  // nibble, low nibble, separator.
  for (genvar gi = 0; gi < FRAME_LEN; gi++) begin : g_char
    localparam int GRP = gi / 4;
    localparam int POS = gi % 4;
    if (POS == 0) begin : g_letter
      if (GRP == 0) begin : g_o
        assign frame_chars[gi] = ASCII_O;
      end else if (GRP == 1) begin : g_a
        assign frame_chars[gi] = ASCII_A;
      end else if (GRP == 2) begin : g_x
        assign frame_chars[gi] = ASCII_X;
      end else begin : g_y
        assign frame_chars[gi] = ASCII_Y;
      end
    end else if (POS == 1) begin : g_hi
      assign frame_chars[gi] = nibble_to_ascii(frame_reg[31-8*GRP -: 4]);
    end else if (POS == 2) begin : g_lo
      assign frame_chars[gi] = nibble_to_ascii(frame_reg[27-8*GRP -: 4]);
    end else if (gi == FRAME_LEN - 1) begin : g_last
`ifdef TRACE_OVF_MARK_EN
      assign frame_chars[gi] = overflow_reg ? ASCII_BANG : ASCII_SPACE;
`else
      assign frame_chars[gi] = ASCII_SPACE;
`endif
    end else begin : g_sep
      assign frame_chars[gi] = ASCII_SPACE;
    end
  end

  assign cur_char = frame_chars[idx_reg[3:0]];

  // State, index, frame, held character and sticky overflow registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      idx_reg      <= '0;
      frame_reg    <= '0;
      data_reg     <= ASCII_SPACE;
      overflow_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      if (fifo_pop) begin
        frame_reg <= fifo_rd_data;
      end
      if (state_reg == ST_CHAR) begin
        data_reg <= cur_char;
      end
      overflow_reg <= overflow_reg | (fifo_drop & fifo_full);
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    fifo_pop   = 1'b0;
    writeStart = 1'b0;
    clrLCD     = 1'b0;
    data       = data_reg;
    case (state_reg)
      ST_IDLE: begin
        if (initDone && !fifo_empty) begin
          fifo_pop   = 1'b1;
          state_next = ST_CLR;
        end
      end
      ST_CLR: begin
        clrLCD     = 1'b1;
        state_next = ST_CLR_WAIT;
      end
      ST_CLR_WAIT: begin
        if (writeDone) begin
          idx_next   = '0;
          state_next = ST_CHAR;
        end
      end
      ST_CHAR: begin
        // Present the character now; data_reg holds it until writeDone.
        data       = cur_char;
        writeStart = 1'b1;
        state_next = ST_CHAR_WAIT;
      end
      ST_CHAR_WAIT: begin
        if (writeDone) begin
          idx_next   = idx_reg + 5'd1;
          state_next = (idx_next == 5'(FRAME_LEN)) ? ST_DONE : ST_CHAR;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign overflow = overflow_reg;
  assign busy     = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_cpu_trace_lcd_fmt.sv
// Directed bench for cpu_trace_lcd_fmt with a snapshot/character scoreboard
// and an LCD model that answers each request with writeDone 5 clk later.
module tb_cpu_trace_lcd_fmt;

  logic       clk = 1'b0;
  logic       rst;
  logic       snap_strobe = 1'b0;
  logic [7:0] accum = 8'h00;
  logic [7:0] xreg = 8'h00;
  logic [7:0] yreg = 8'h00;
  logic [7:0] opcode = 8'h00;
  logic       initDone = 1'b0;
  logic       writeDone;
  logic       writeStart;
  logic       clrLCD;
  logic [7:0] data;
  logic       overflow;
  logic       busy;

  logic       wd_resp = 1'b0;
  logic       wd_stray = 1'b0;
  assign writeDone = wd_resp | wd_stray;

  cpu_trace_lcd_fmt #(.FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .snap_strobe (snap_strobe),
    .accum       (accum),
    .xreg        (xreg),
    .yreg        (yreg),
    .opcode      (opcode),
    .initDone    (initDone),
    .writeDone   (writeDone),
    .writeStart  (writeStart),
    .clrLCD      (clrLCD),
    .data        (data),
    .overflow    (overflow),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_q [$];
  logic [7:0]  exp_q [$];
  bit          model_ovf = 1'b0;
  int          resp_cnt = 0;
  int          clr_seen = 0;
  int          ws_seen = 0;
  bit          wait_char = 1'b0;
  logic [7:0]  last_data = 8'h20;
  string       HEXS = "0123456789ABCDEF";
  string       LETTERS = "OAXY";

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Expand one snapshot into the 16 characters the LCD should receive.
  task automatic push_frame(input logic [31:0] f);
    logic [7:0] b [4];
    bit mark;
    b[0] = f[31:24];
    b[1] = f[23:16];
    b[2] = f[15:8];
    b[3] = f[7:0];
`ifdef TRACE_OVF_MARK_EN
    mark = model_ovf;
`else
    mark = 1'b0;
`endif
    for (int g = 0; g < 4; g++) begin
      exp_q.push_back(LETTERS[g]);
      exp_q.push_back(HEXS[b[g][7:4]]);
      exp_q.push_back(HEXS[b[g][3:0]]);
      exp_q.push_back((g == 3 && mark) ? 8'h21 : 8'h20);
    end
  endtask

  // LCD model and scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      model_q.delete();
      model_ovf = 1'b0;
      resp_cnt  = 0;
      wd_resp   = 1'b0;
      wait_char = 1'b0;
    end else begin
      wd_resp = 1'b0;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          wd_resp   = 1'b1;
          wait_char = 1'b0;
        end
      end
      if (wait_char && !writeStart) begin
        chk("data_hold", 32'(data), 32'(last_data));
      end
      if (clrLCD) begin
        clr_seen++;
        chk("clr_expected", 32'(model_q.size() != 0), 32'd1);
        if (model_q.size() != 0) push_frame(model_q.pop_front());
        resp_cnt = 5;
      end
      if (writeStart) begin
        ws_seen++;
        chk("ws_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("char", 32'(data), 32'(exp_q.pop_front()));
        last_data = data;
        wait_char = 1'b1;
        resp_cnt  = 5;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Raise the strobe away from the clock edge, hold it 'hold' clocks.
  task automatic do_strobe(input logic [7:0] op, input logic [7:0] a,
                           input logic [7:0] x, input logic [7:0] y, input int hold);
    @(posedge clk);
    #3;
    opcode = op;
    accum  = a;
    xreg   = x;
    yreg   = y;
    snap_strobe = 1'b1;
    if (model_q.size() < 4) model_q.push_back({op, a, x, y});
    else model_ovf = 1'b1;
    repeat (hold) @(posedge clk);
    #3;
    snap_strobe = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      tick();
      done = (model_q.size() == 0) && (exp_q.size() == 0) && !busy && (resp_cnt == 0);
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, w0, n;
    bit found;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_writeStart", 32'(writeStart), 32'd0);
    chk("rst_clrLCD", 32'(clrLCD), 32'd0);
    chk("rst_data", 32'(data), 32'h20);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();

    // Single frame, with busy dropping one clock after DONE.
    initDone = 1'b1;
    c0 = clr_seen;
    w0 = ws_seen;
    do_strobe(8'hA9, 8'h3C, 8'h00, 8'hFF, 4);
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      tick();
      if (ws_seen - w0 == 16 && writeDone === 1'b1) found = 1'b1;
    end
    chk("t1_last_done_seen", 32'(found), 32'd1);
    chk("t1_busy_in_done", 32'(busy), 32'd1);
    tick();
    chk("t1_busy_fall", 32'(busy), 32'd0);
    wait_idle("t1_idle", 100);
    chk("t1_clears", 32'(clr_seen - c0), 32'd1);
    chk("t1_writes", 32'(ws_seen - w0), 32'd16);

    // Snapshots queue while the LCD is not initialised.
    initDone = 1'b0;
    c0 = clr_seen;
    w0 = ws_seen;
    do_strobe(8'h01, 8'h23, 8'h45, 8'h67, 2);
    do_strobe(8'h89, 8'hAB, 8'hCD, 8'hEF, 2);
    do_strobe(8'hFE, 8'hDC, 8'hBA, 8'h98, 2);
    repeat (20) tick();
    chk("t2_no_emit", 32'((clr_seen - c0) + (ws_seen - w0)), 32'd0);
    chk("t2_busy_idle", 32'(busy), 32'd0);
    initDone = 1'b1;
    wait_idle("t2_idle", 2000);
    chk("t2_frames", 32'(clr_seen - c0), 32'd3);
    chk("t2_writes", 32'(ws_seen - w0), 32'd48);

    // Six snapshots into a four-deep queue: two dropped, overflow sticks.
    initDone = 1'b0;
    c0 = clr_seen;
    for (int s = 0; s < 6; s++) begin
      do_strobe(8'(8'h10 + s), 8'(8'h20 + s), 8'(8'h30 + s), 8'(8'h40 + s), 2);
    end
    chk("t3_overflow", 32'(overflow), 32'd1);
    initDone = 1'b1;
    wait_idle("t3_idle", 3000);
    chk("t3_frames", 32'(clr_seen - c0), 32'd4);
    chk("t3_overflow_sticky", 32'(overflow), 32'd1);

    // Reset while the seventh character is being requested.
    w0 = ws_seen;
    do_strobe(8'h5A, 8'hC3, 8'h7E, 8'h81, 2);
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      tick();
      if (ws_seen - w0 == 6 && writeStart === 1'b1) found = 1'b1;
    end
    chk("t4_seventh_char", 32'(found), 32'd1);
    rst = 1'b1;
    #1;
    chk("t4_writeStart", 32'(writeStart), 32'd0);
    chk("t4_clrLCD", 32'(clrLCD), 32'd0);
    chk("t4_data", 32'(data), 32'h20);
    chk("t4_overflow", 32'(overflow), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    c0 = clr_seen;
    w0 = ws_seen;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (writeStart || clrLCD) n++;
    end
    chk("t4_quiet_after_reset", 32'(n + (clr_seen - c0) + (ws_seen - w0)), 32'd0);

    // Long strobe, then a one-clock strobe: one capture per edge.
    c0 = clr_seen;
    do_strobe(8'hC0, 8'hDE, 8'h12, 8'h34, 100);
    do_strobe(8'h0F, 8'hF0, 8'h99, 8'h66, 1);
    wait_idle("t5_idle", 2000);
    chk("t5_frames", 32'(clr_seen - c0), 32'd2);

    // Stray writeDone pulses while idle must not start anything.
    c0 = clr_seen;
    w0 = ws_seen;
    for (int i = 0; i < 3; i++) begin
      wd_stray = 1'b1;
      tick();
      wd_stray = 1'b0;
      tick();
    end
    repeat (10) tick();
    chk("t5_stray_quiet", 32'((clr_seen - c0) + (ws_seen - w0)), 32'd0);
    chk("t5_stray_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
